// File: rtl/exu_div_iter.sv
// ============================================================================
// exu_div_iter : radix-2 restoring iterative integer divider (DIV/REM, *W)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module exu_div_iter #(
    parameter int XLEN     = 64,
    parameter bit HAS_WORD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            op_word,
    input  logic            op_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_zero,
    output logic            ovf
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 2);

    localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] x);
        return {{HALF{x[HALF-1]}}, x};
    endfunction

    function automatic logic [XLEN-1:0] zext_half(input logic [HALF-1:0] x);
        return {{HALF{1'b0}}, x};
    endfunction

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_acc;
    logic [XLEN-1:0] quo_acc;
    logic [XLEN-1:0] div_mag;
    logic            word_q;
    logic            q_neg;
    logic            r_neg;

    logic            word_in;
    logic            dvd_sign;
    logic            dsr_sign;
    logic [XLEN-1:0] dvd_ext;
    logic [XLEN-1:0] dsr_ext;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dsr_mag;
    logic [XLEN-1:0] dvd_align;
    logic            dsr_zero;
    logic            dvd_min;
    logic            dsr_neg1;
    logic            is_ovf;
    logic [XLEN-1:0] wide_in;

    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] q_sgn;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_sgn;
    logic [XLEN-1:0] r_fin;

    always_comb begin
        word_in   = HAS_WORD && op_word;
        dvd_sign  = word_in ? dividend[HALF-1] : dividend[XLEN-1];
        dsr_sign  = word_in ? divisor[HALF-1]  : divisor[XLEN-1];
        dvd_ext   = dividend;
        dsr_ext   = divisor;
        if (word_in) begin
            dvd_ext = op_signed ? sext_half(dividend[HALF-1:0]) : zext_half(dividend[HALF-1:0]);
            dsr_ext = op_signed ? sext_half(divisor[HALF-1:0])  : zext_half(divisor[HALF-1:0]);
        end
        dvd_mag   = (op_signed && dvd_sign) ? -dvd_ext : dvd_ext;
        dsr_mag   = (op_signed && dsr_sign) ? -dsr_ext : dsr_ext;
        // word operands are pre-shifted so their MSB is the first bit consumed
        dvd_align = word_in ? (dvd_mag << HALF) : dvd_mag;
        dsr_zero  = word_in ? (divisor[HALF-1:0] == '0) : (divisor == '0);
        dvd_min   = word_in ? (dividend[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                            : (dividend == {1'b1, {(XLEN-1){1'b0}}});
        dsr_neg1  = word_in ? (&divisor[HALF-1:0]) : (&divisor);
        is_ovf    = op_signed && dvd_min && dsr_neg1;
        wide_in   = word_in ? sext_half(dividend[HALF-1:0]) : dividend;
    end

    always_comb begin
        trial  = {rem_acc, quo_acc[XLEN-1]};
        ge     = trial >= {1'b0, div_mag};
        rem_nx = ge ? XLEN'(trial - {1'b0, div_mag}) : XLEN'(trial);
        quo_nx = {quo_acc[XLEN-2:0], ge};
        q_mag  = word_q ? zext_half(quo_nx[HALF-1:0]) : quo_nx;
        q_sgn  = q_neg ? -q_mag : q_mag;
        q_fin  = word_q ? sext_half(q_sgn[HALF-1:0]) : q_sgn;
        r_sgn  = r_neg ? -rem_nx : rem_nx;
        r_fin  = word_q ? sext_half(r_sgn[HALF-1:0]) : r_sgn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            div_mag   <= '0;
            word_q    <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        word_q   <= word_in;
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                        if (dsr_zero) begin
                            quotient  <= '1;
                            remainder <= wide_in;
                            div_zero  <= 1'b1;
                            state     <= S_DONE;
                        end else if (is_ovf) begin
                            quotient  <= wide_in;
                            remainder <= '0;
                            ovf       <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            rem_acc <= '0;
                            quo_acc <= dvd_align;
                            div_mag <= dsr_mag;
                            q_neg   <= op_signed && (dvd_sign ^ dsr_sign);
                            r_neg   <= op_signed && dvd_sign;
                            cnt     <= word_in ? CNT_HALF : CNT_FULL;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_acc <= rem_nx;
                    quo_acc <= quo_nx;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

`default_nettype wire
